exec_trace_fifo: RTL and testbench
==================================

# exec_trace_fifo

Execution-trace capture buffer sitting directly downstream of the `TOP` datapath. Each cycle it watches the program counter, fetched instruction, register write-back value and ALU flag. When a new instruction is seen and it passes the capture filter, it pushes a trace record into an internal FIFO. A debug consumer drains records over a valid/ready interface; records that cannot be stored are counted, not silently lost.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..64
- DROP_W, 16, width of the dropped-record counter
- clk  in  1  rising-edge clock, shared with `TOP`
- rst  in  1  asynchronous, active-low reset
- trace_en  in  1  capture enable; 0 blocks new pushes, draining continues
- flag_only  in  1  0 = capture every new instruction; 1 = capture only when flag_in = 1
- pc_in  in  [0:31]  program counter from `TOP` (PC_Out)
- inst_in  in  [0:31]  instruction word (Imemo_Inst)
- rw_in  in  [0:31]  write-back value (RAM_Rw)
- flag_in  in  1  ALU flag (ALU_Flag)
- out_valid  out  1  head record available
- out_ready  in  1  consumer accepts head record
- out_pc  out  [0:31]  head record PC
- out_inst  out  [0:31]  head record instruction
- out_rw  out  [0:31]  head record write-back value
- out_flag  out  1  head record flag
- fill  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- drop_cnt  out  DROP_W  records rejected because the FIFO was full; saturates

## Operation
- The block holds `last_pc` and a `primed` bit; reset sets primed = 0.
- A new instruction is present when primed = 0 or pc_in != last_pc.
- The capture candidate is trace_en AND new AND (flag_only = 0 OR flag_in = 1).
- On every clock edge where trace_en = 1, the block loads `last_pc <= pc_in` and sets primed = 1, independent of the filter and of FIFO state.
- A record is {pc_in, inst_in, rw_in, flag_in}, sampled on the capture edge.
- pop = out_valid AND out_ready.
- push = candidate AND (fill < DEPTH OR pop).
  - A full FIFO with a simultaneous pop accepts the push, and fill is unchanged.
- candidate AND NOT push increments drop_cnt by 1, saturating at all-ones; it never wraps.
- Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- fill tracks +1 on push only, −1 on pop only, and no change on both or neither.
- out_valid = (fill != 0).
- out_* present the head entry combinationally from the storage array.
- When fill = 0, out_pc, out_inst, out_rw and out_flag are driven to 0.
- Records leave in strict capture order; there is no reordering and no overwrite.

## Timing
- Reset (rst = 0, asynchronous) clears:
  - pointers, fill and drop_cnt to 0
  - primed to 0, last_pc to 0
  - out_valid to 0, and out_pc, out_inst, out_rw, out_flag to 0
- Storage contents are not reset.
- Reset asserted mid-operation discards all buffered records immediately; release is synchronous to the next clk edge.
- Capture latency: a record sampled on edge N is visible on out_* with out_valid = 1 after edge N (one cycle), when the FIFO was empty.
- A pop on edge N presents the next entry, or out_valid = 0, after edge N.
- Back-to-back push and pop sustain one record per cycle indefinitely with fill constant.
- A stalled consumer (out_ready = 0) holds out_* stable; out_valid, once high, stays high until popped or reset.
- drop_cnt and fill update on the same edge as the push/pop decision.

## Test plan
- Basic capture:
  - Stimulus: reset, trace_en = 1, flag_only = 0, out_ready = 1; pc_in steps 0,4,8 with inst_in = 0x11111111, 0x22222222, 0x33333333.
  - Required response: three records in order, out_pc = 0,4,8; fill never exceeds 1; drop_cnt = 0.
- PC hold:
  - Stimulus: pc_in = 0x10 for 5 cycles.
  - Required response: exactly one record captured.
- Flag filter:
  - Stimulus: flag_only = 1; PCs 0,4,8,12 with flag_in = 0,1,0,1.
  - Required response: two records, out_pc = 4 then 12, out_flag = 1.
- Overflow:
  - Stimulus: DEPTH = 8, out_ready = 0, 11 distinct PCs.
  - Required response: fill = 8, drop_cnt = 3; draining yields the first 8 PCs in order, after which out_valid = 0.
- Full plus simultaneous pop:
  - Stimulus: FIFO full, out_ready = 1 while a new PC arrives.
  - Required response: push accepted, fill stays 8, drop_cnt unchanged.
- Reset mid-stream:
  - Stimulus: fill = 5, pull rst low between edges.
  - Required response: out_valid = 0, fill = 0, drop_cnt = 0 immediately. After release, the first valid PC is captured even if it equals the pre-reset last_pc.

Source files
------------

// File: rtl/exec_trace_fifo_if.sv
// rtl/exec_trace_fifo_if.sv - trace record stream from the capture FIFO to the debug consumer
interface exec_trace_fifo_if;
    logic        out_valid;
    logic        out_ready;
    logic [0:31] out_pc;
    logic [0:31] out_inst;
    logic [0:31] out_rw;
    logic        out_flag;

    modport master (
        output out_valid,
        output out_pc,
        output out_inst,
        output out_rw,
        output out_flag,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_pc,
        input  out_inst,
        input  out_rw,
        input  out_flag,
        output out_ready
    );
endinterface

// File: rtl/exec_trace_fifo.sv
// rtl/exec_trace_fifo.sv - execution-trace capture filter feeding a record FIFO with drop counting
module exec_trace_fifo #(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_en,
    input  logic                     flag_only,
    input  logic [0:31]              pc_in,
    input  logic [0:31]              inst_in,
    input  logic [0:31]              rw_in,
    input  logic                     flag_in,
    exec_trace_fifo_if.master        trc,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [DROP_W-1:0]        drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE    = AW'(1);
    localparam logic [AW:0]     FILL_ONE   = (AW+1)'(1);
    localparam logic [AW:0]     FILL_DEPTH = (AW+1)'(DEPTH);
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

    logic [0:31]   mem_pc   [DEPTH];
    logic [0:31]   mem_inst [DEPTH];
    logic [0:31]   mem_rw   [DEPTH];
    logic          mem_flag [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [0:31]   last_pc;
    logic          primed;

    logic          is_new;
    logic          candidate;
    logic          valid;
    logic          pop;
    logic          push;

    // The first enabled cycle after reset always counts as a new instruction.
    assign is_new    = !primed || (pc_in != last_pc);
    assign candidate = trace_en && is_new && (!flag_only || flag_in);
    assign valid     = (fill != '0);
    assign pop       = valid && trc.out_ready;
    // A full FIFO can still take a record when the head leaves on the same edge.
    assign push      = candidate && ((fill < FILL_DEPTH) || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            drop_cnt <= '0;
            last_pc  <= '0;
            primed   <= 1'b0;
        end else begin
            if (trace_en) begin
                last_pc <= pc_in;
                primed  <= 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
                fill <= fill + FILL_ONE;
            else if (pop && !push)
                fill <= fill - FILL_ONE;
            if (candidate && !push && (drop_cnt != '1))
                drop_cnt <= drop_cnt + DROP_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= pc_in;
            mem_inst[wr_ptr] <= inst_in;
            mem_rw[wr_ptr]   <= rw_in;
            mem_flag[wr_ptr] <= flag_in;
        end
    end

    // Storage is not reset, so the head is masked whenever the FIFO is empty.
    assign trc.out_valid = valid;
    assign trc.out_pc    = valid ? mem_pc[rd_ptr]   : '0;
    assign trc.out_inst  = valid ? mem_inst[rd_ptr] : '0;
    assign trc.out_rw    = valid ? mem_rw[rd_ptr]   : '0;
    assign trc.out_flag  = valid ? mem_flag[rd_ptr] : 1'b0;
endmodule

// File: tb/tb_exec_trace_fifo.sv
// tb/tb_exec_trace_fifo.sv - testbench for exec_trace_fifo
module tb_exec_trace_fifo;
    localparam int DEPTH  = 8;
    localparam int DROP_W = 16;

    typedef struct {
        logic        te;
        logic        fo;
        logic [0:31] pc;
        logic [0:31] inst;
        logic [0:31] rw;
        logic        flag;
        logic        ready;
        int          exp_fill;
        int          exp_drop;
    } vec_t;

    typedef struct {
        logic [0:31] pc;
        logic [0:31] inst;
        logic [0:31] rw;
        logic        flag;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_en;
    logic        flag_only;
    logic [0:31] pc_in;
    logic [0:31] inst_in;
    logic [0:31] rw_in;
    logic        flag_in;
    logic [$clog2(DEPTH):0] fill;
    logic [DROP_W-1:0]      drop_cnt;

    exec_trace_fifo_if tif ();

    exec_trace_fifo #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .trace_en  (trace_en),
        .flag_only (flag_only),
        .pc_in     (pc_in),
        .inst_in   (inst_in),
        .rw_in     (rw_in),
        .flag_in   (flag_in),
        .trc       (tif.master),
        .fill      (fill),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    rec_t        sb_q[$];
    int          m_drop   = 0;
    logic        m_primed = 1'b0;
    logic [0:31] m_last   = '0;
    vec_t        tbl[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic te, input logic fo, input logic [0:31] pc,
                                input logic [0:31] inst, input logic [0:31] rw,
                                input logic flag, input logic ready,
                                input int ef, input int ed);
        vec_t v;
        v.te = te; v.fo = fo; v.pc = pc; v.inst = inst; v.rw = rw;
        v.flag = flag; v.ready = ready; v.exp_fill = ef; v.exp_drop = ed;
        return v;
    endfunction

    // Called about 1 time unit after a rising edge; leaves time 1 unit after the next one.
    task automatic step(input vec_t v);
        rec_t r;
        logic m_pop;
        logic cand;
        logic m_push;
        trace_en      = v.te;
        flag_only     = v.fo;
        pc_in         = v.pc;
        inst_in       = v.inst;
        rw_in         = v.rw;
        flag_in       = v.flag;
        tif.out_ready = v.ready;
        #1;
        chk("out_valid", {63'd0, tif.out_valid}, {63'd0, sb_q.size() != 0});
        if (sb_q.size() != 0)
            chk("head_pc", {32'd0, tif.out_pc}, {32'd0, sb_q[0].pc});
        else
            chk("idle_pc", {32'd0, tif.out_pc}, 64'd0);
        m_pop  = (sb_q.size() != 0) && v.ready;
        cand   = v.te && (!m_primed || (v.pc != m_last)) && (!v.fo || v.flag);
        m_push = cand && ((sb_q.size() < DEPTH) || m_pop);
        if (cand && !m_push) m_drop++;
        if (m_pop) begin
            r = sb_q.pop_front();
            chk("pop_inst", {32'd0, tif.out_inst}, {32'd0, r.inst});
            chk("pop_rw",   {32'd0, tif.out_rw},   {32'd0, r.rw});
            chk("pop_flag", {63'd0, tif.out_flag}, {63'd0, r.flag});
        end
        if (m_push) begin
            r.pc = v.pc; r.inst = v.inst; r.rw = v.rw; r.flag = v.flag;
            sb_q.push_back(r);
        end
        if (v.te) begin
            m_primed = 1'b1;
            m_last   = v.pc;
        end
        @(posedge clk);
        #1;
        chk("fill",     64'(fill),     64'(sb_q.size()));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    endtask

    initial begin
        rst = 1'b0;
        trace_en = 1'b0; flag_only = 1'b0; flag_in = 1'b0;
        pc_in = '0; inst_in = '0; rw_in = '0;
        tif.out_ready = 1'b0;

        // basic capture, PC hold, flag filter
        tbl[0]  = mk(1, 0, 32'h0,  32'h11111111, 32'hA0, 0, 1, 1, 0);
        tbl[1]  = mk(1, 0, 32'h4,  32'h22222222, 32'hA4, 1, 1, 1, 0);
        tbl[2]  = mk(1, 0, 32'h8,  32'h33333333, 32'hA8, 0, 1, 1, 0);
        tbl[3]  = mk(1, 0, 32'h10, 32'h44444444, 32'hB0, 1, 1, 1, 0);
        tbl[4]  = mk(1, 0, 32'h10, 32'h55555555, 32'hB1, 0, 1, 0, 0);
        tbl[5]  = mk(1, 0, 32'h10, 32'h55555555, 32'hB2, 0, 1, 0, 0);
        tbl[6]  = mk(1, 0, 32'h10, 32'h55555555, 32'hB3, 0, 1, 0, 0);
        tbl[7]  = mk(1, 0, 32'h10, 32'h55555555, 32'hB4, 0, 1, 0, 0);
        tbl[8]  = mk(1, 1, 32'h0,  32'h66666666, 32'hC0, 0, 1, 0, 0);
        tbl[9]  = mk(1, 1, 32'h4,  32'h77777777, 32'hC4, 1, 1, 1, 0);
        tbl[10] = mk(1, 1, 32'h8,  32'h88888888, 32'hC8, 0, 1, 0, 0);
        tbl[11] = mk(1, 1, 32'hC,  32'h99999999, 32'hCC, 1, 1, 1, 0);
        tbl[12] = mk(1, 1, 32'hC,  32'h99999999, 32'hCC, 0, 1, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, tif.out_valid}, 64'd0);
        chk("rst_fill",  64'(fill), 64'd0);
        chk("rst_drop",  64'(drop_cnt), 64'd0);
        chk("rst_pc",    {32'd0, tif.out_pc}, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i]);
            chk($sformatf("vec%0d_fill", i), 64'(fill), 64'(tbl[i].exp_fill));
            chk($sformatf("vec%0d_drop", i), 64'(drop_cnt), 64'(tbl[i].exp_drop));
        end

        // overflow: 11 distinct PCs into a stalled 8-deep FIFO
        for (int i = 0; i < 11; i++)
            step(mk(1, 0, 32'h100 + 32'(4 * i), 32'hD000 + 32'(i), 32'hE000 + 32'(i), i[0], 0, 0, 0));
        chk("ovf_fill", 64'(fill), 64'd8);
        chk("ovf_drop", 64'(drop_cnt), 64'd3);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_pc%0d", i), {32'd0, tif.out_pc}, 64'(32'h100 + 32'(4 * i)));
            step(mk(0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 0, 0));
        end
        chk("drained_valid", {63'd0, tif.out_valid}, 64'd0);

        // full FIFO with simultaneous pop and push
        for (int i = 0; i < 8; i++)
            step(mk(1, 0, 32'h200 + 32'(4 * i), 32'hF000 + 32'(i), 32'hF100 + 32'(i), 1, 0, 0, 0));
        chk("full_fill", 64'(fill), 64'd8);
        step(mk(1, 0, 32'h300, 32'hCAFE0300, 32'hBEEF0300, 0, 1, 0, 0));
        chk("fullpop_fill", 64'(fill), 64'd8);
        chk("fullpop_drop", 64'(drop_cnt), 64'd3);
        chk("fullpop_head", {32'd0, tif.out_pc}, 64'h204);
        for (int i = 0; i < 3; i++)
            step(mk(0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 0, 0));
        chk("pre_rst_fill", 64'(fill), 64'd5);

        // asynchronous reset between edges
        rst = 1'b0;
        #1;
        chk("midrst_valid", {63'd0, tif.out_valid}, 64'd0);
        chk("midrst_fill",  64'(fill), 64'd0);
        chk("midrst_drop",  64'(drop_cnt), 64'd0);
        chk("midrst_pc",    {32'd0, tif.out_pc}, 64'd0);
        sb_q.delete();
        m_drop = 0; m_primed = 1'b0; m_last = '0;
        #1;
        rst = 1'b1;
        step(mk(1, 0, 32'h300, 32'h12345678, 32'h9ABC, 1, 0, 0, 0));
        chk("postrst_fill", 64'(fill), 64'd1);
        chk("postrst_pc",   {32'd0, tif.out_pc}, 64'h300);
        step(mk(1, 0, 32'h300, 32'h12345678, 32'h9ABC, 1, 1, 0, 0));
        chk("postrst_empty", 64'(fill), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
